if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the 32-word instruction memory and drives its byte address.
- Holds the PC and consumes the combinational instruction word the memory returns. Registers it into the IF/ID pipeline register with PC+4 and a valid bit.
- Provides start gating (fetch only after the memory image is loaded), stall hold, flush/redirect for branches and jumps, and halt detection.

---
 rtl/if_fetch_stage.sv | 102 ++++++++++
 tb/tb_if_fetch_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage with start gating, stall hold, redirect and halt detection.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls,
`endif
   output logic        halted
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, instr_n, pc4_n, pc_inc, target;
   logic valid_n, fetch;
   assign imem_addr = pc;
   assign pc_inc    = pc + 32'd4;
   assign target    = {redirect_pc[31:2], 2'b00};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         if_id_instr <= '0;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         if_id_instr <= instr_n;
         if_id_pc4   <= pc4_n;
         if_id_valid <= valid_n;
         halted      <= state_n == HALT;
      end
   end
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = if_id_instr;
      pc4_n   = if_id_pc4;
      valid_n = if_id_valid;
      fetch   = 1'b0;
      case (state)
         IDLE: begin
            pc_n    = RESET_PC;
            valid_n = 1'b0;
            state_n = start ? RUN : IDLE;
         end
         RUN: begin
            // Redirect beats stall: the wrong-path slot is squashed even while stalled.
            if (redirect) begin
               pc_n    = target;
               instr_n = '0;
               valid_n = 1'b0;
            end else if (!stall) begin
               if (imem_instr == HALT_INSTR) begin
                  instr_n = '0;
                  valid_n = 1'b0;
                  state_n = HALT;
               end else begin
                  fetch   = 1'b1;
                  pc_n    = pc_inc;
                  instr_n = imem_instr;
                  pc4_n   = pc_inc;
                  valid_n = 1'b1;
               end
            end
         end
         default: begin
            instr_n = '0;
            valid_n = 1'b0;
            if (redirect) begin
               pc_n    = target;
               state_n = RUN;
            end
         end
      endcase
   end
`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (fetch && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (state == RUN && stall && !redirect && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: vector table driven through an expected-result queue, plus async-reset sequence.
module tb_if_fetch_stage;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0, imem_addr, imem_instr, if_id_instr, if_id_pc4;
   logic if_id_valid, halted;
   logic [31:0] mem [32];
   int checks = 0, errors = 0;

   typedef struct {
      logic start, stall, redirect;
      logic [31:0] rpc, addr, instr, pc4;
      logic valid, halted;
   } vec_t;
   vec_t vecs[$];
   vec_t exp_q[$];

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted)
   );

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr[6:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, " imem_addr"}, imem_addr, e.addr);
      chk({tag, " if_id_instr"}, if_id_instr, e.instr);
      chk({tag, " if_id_pc4"}, if_id_pc4, e.pc4);
      chk({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
      chk({tag, " halted"}, {31'd0, halted}, {31'd0, e.halted});
   endtask

   task automatic add(input logic st, input logic sl, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] a, input logic [31:0] ins, input logic [31:0] p4,
                      input logic v, input logic h);
      vecs.push_back('{st, sl, rd, rpc, a, ins, p4, v, h});
   endtask

   task automatic idle_exp(input string tag, input vec_t e);
      @(negedge clk);
      {start, stall, redirect} = 3'b000;
      @(posedge clk);
      #1 chk_all(tag, e);
   endtask

   initial begin
      vec_t e, got;
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      mem[4] = 32'hFFFF_FFFF;
      //  start stall redir rpc           addr          instr     pc4      v  h
      add(0, 0, 1, 32'h40,        32'h0,        32'h0,    32'h0,   0, 0);
      add(1, 0, 1, 32'h40,        32'h0,        32'h0,    32'h0,   0, 0);
      add(0, 0, 0, 32'h0,         32'h4,        32'h11,   32'h4,   1, 0);
      add(0, 0, 0, 32'h0,         32'h8,        32'h22,   32'h8,   1, 0);
      add(0, 1, 0, 32'h0,         32'h8,        32'h22,   32'h8,   1, 0);
      add(0, 1, 0, 32'h0,         32'h8,        32'h22,   32'h8,   1, 0);
      add(0, 1, 0, 32'h0,         32'h8,        32'h22,   32'h8,   1, 0);
      add(0, 0, 0, 32'h0,         32'hC,        32'h33,   32'hC,   1, 0);
      add(0, 1, 1, 32'h23,        32'h20,       32'h0,    32'hC,   0, 0);
      add(0, 0, 0, 32'h0,         32'h24,       32'h1008, 32'h24,  1, 0);
      add(0, 0, 1, 32'hE,         32'hC,        32'h0,    32'h24,  0, 0);
      add(0, 0, 0, 32'h0,         32'h10,       32'h44,   32'h10,  1, 0);
      add(0, 0, 0, 32'h0,         32'h10,       32'h0,    32'h10,  0, 1);
      add(1, 0, 0, 32'h0,         32'h10,       32'h0,    32'h10,  0, 1);
      add(0, 1, 0, 32'h0,         32'h10,       32'h0,    32'h10,  0, 1);
      add(0, 0, 1, 32'h0,         32'h0,        32'h0,    32'h10,  0, 0);
      add(0, 0, 0, 32'h0,         32'h4,        32'h11,   32'h4,   1, 0);
      add(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,   32'h4,   0, 0);
      add(0, 0, 0, 32'h0,         32'h0,        32'h101F, 32'h0,   1, 0);
      add(0, 0, 1, 32'h10,        32'h10,       32'h0,    32'h0,   0, 0);
      add(0, 1, 0, 32'h0,         32'h10,       32'h0,    32'h0,   0, 0);
      add(0, 0, 1, 32'h14,        32'h14,       32'h0,    32'h0,   0, 0);

      #1 chk_all("reset", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         start = vecs[i].start; stall = vecs[i].stall;
         redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at vector %0d", i);
         end else begin
            got = exp_q.pop_front();
            chk_all($sformatf("vec%0d", i), got);
         end
      end

      // Async reset mid-RUN at PC=0x14 must clear outputs without a clock edge.
      @(negedge clk) {start, stall, redirect} = 3'b000;
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
      @(negedge clk) rst_n = 1'b1;
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      idle_exp("post_rst_idle0", e);
      idle_exp("post_rst_idle1", e);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 chk_all("restart", e);
      e = '{0, 0, 0, 0, 32'h4, 32'h11, 32'h4, 1, 0};
      idle_exp("refetch", e);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
